// File: rtl/xio_input_debounce.sv
// Eight-channel input conditioner: 2-flop synchronizer, tick-sampled debounce,
// rise/fall pulses, and a pending-flag scanner feeding a 4-entry event FIFO.
module xio_input_debounce #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] XIO_IN,
  output logic [7:0] DB_OUT,
  output logic [7:0] RISE,
  output logic [7:0] FALL,
  output logic       EVT_VALID,
  output logic [3:0] EVT_DATA,
  input  logic       EVT_READY,
  output logic       EVT_OVERFLOW,
  input  logic       CLR_OVF
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    CNT_LAST   = 3'(STABLE_COUNT - 1);

  typedef enum logic {SCAN_IDLE, SCAN_PUSH} scan_state_t;

  logic [7:0]      sync_a;
  logic [7:0]      sync_b;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [7:0][2:0] stable_cnt;
  logic [7:0]      differ;
  logic [7:0]      accept;
  logic [7:0]      pend_rise;
  logic [7:0]      pend_fall;
  logic [7:0]      svc_rise;
  logic [7:0]      svc_fall;
  scan_state_t     state;
  scan_state_t     state_next;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            drop;
  logic            found;
  logic [3:0]      push_data;
  logic [3:0]      head_next;
  logic [3:0]      mem [4];
  logic [1:0]      wr_ptr;
  logic [1:0]      rd_ptr;
  logic [1:0]      rd_next;
  logic [2:0]      fcnt;
  logic [2:0]      fcnt_next;

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      sync_a <= '0;
      sync_b <= '0;
      presc  <= '0;
    end else begin
      sync_a <= XIO_IN;
      sync_b <= sync_a;
      presc  <= tick ? '0 : presc + 1'b1;
    end
  end

  assign tick   = (presc == PRESC_LAST);
  assign differ = sync_b ^ DB_OUT;

  // A bit is accepted on the tick that completes its run of differing samples.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 8; i++)
      accept[i] = tick && differ[i] && (stable_cnt[i] == CNT_LAST);
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      stable_cnt <= '0;
      DB_OUT     <= '0;
      RISE       <= '0;
      FALL       <= '0;
      pend_rise  <= '0;
      pend_fall  <= '0;
    end else begin
      DB_OUT    <= DB_OUT ^ accept;
      RISE      <= accept & sync_b;
      FALL      <= accept & ~sync_b;
      pend_rise <= (pend_rise & ~svc_rise) | (accept & sync_b);
      pend_fall <= (pend_fall & ~svc_fall) | (accept & ~sync_b);
      if (tick)
        for (int i = 0; i < 8; i++)
          stable_cnt[i] <= (differ[i] && !accept[i]) ? stable_cnt[i] + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST)
      state <= SCAN_IDLE;
    else
      state <= state_next;
  end

  // Scanner: lowest pending index first, and a fall ahead of a rise on that index.
  always_comb begin
    state_next = state;
    svc_rise   = '0;
    svc_fall   = '0;
    push_req   = 1'b0;
    push_data  = 4'h0;
    found      = 1'b0;
    case (state)
      SCAN_IDLE: begin
        if (|{pend_rise, pend_fall})
          state_next = SCAN_PUSH;
      end
      SCAN_PUSH: begin
        for (int i = 0; i < 8; i++) begin
          if (!found && (pend_fall[i] || pend_rise[i])) begin
            found    = 1'b1;
            push_req = 1'b1;
            if (pend_fall[i]) begin
              svc_fall[i] = 1'b1;
              push_data   = {1'b0, 3'(i)};
            end else begin
              svc_rise[i] = 1'b1;
              push_data   = {1'b1, 3'(i)};
            end
          end
        end
        if (((pend_rise & ~svc_rise) | (pend_fall & ~svc_fall)) == 8'h00)
          state_next = SCAN_IDLE;
      end
      default: state_next = SCAN_IDLE;
    endcase
  end

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  always_comb begin
    pop       = EVT_VALID && EVT_READY;
    push_ok   = push_req && ((fcnt != 3'd4) || pop);
    drop      = push_req && !push_ok;
    rd_next   = rd_ptr + {1'b0, pop};
    fcnt_next = fcnt + {2'b00, push_ok} - {2'b00, pop};
    head_next = (push_ok && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++)
        mem[i] <= 4'h0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fcnt         <= '0;
      EVT_VALID    <= 1'b0;
      EVT_DATA     <= 4'h0;
      EVT_OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      rd_ptr    <= rd_next;
      fcnt      <= fcnt_next;
      EVT_VALID <= (fcnt_next != 3'd0);
      EVT_DATA  <= (fcnt_next != 3'd0) ? head_next : 4'h0;
      if (drop)
        EVT_OVERFLOW <= 1'b1;
      else if (CLR_OVF)
        EVT_OVERFLOW <= 1'b0;
    end
  end

endmodule
